// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS main control FSM: opcodes, states
// and the select codes driven onto the datapath and ALU control decoder.
package mips_ctrl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_MEMADR = 4'd3,
    S_MEMRD  = 4'd4,
    S_MEMWB  = 4'd5,
    S_MEMWR  = 4'd6,
    S_EXEC   = 4'd7,
    S_ALUWB  = 4'd8,
    S_BRANCH = 4'd9,
    S_ADDIEX = 4'd10,
    S_ADDIWB = 4'd11,
    S_JUMP   = 4'd12,
    S_HALT   = 4'd13
  } state_t;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_RT      = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

endpackage

// File: rtl/mips_multicycle_control.sv
// Main control FSM for the multicycle MIPS datapath: opcode decode, datapath
// enables/selects, ALUOp for the ALU control decoder and a retired-instruction count.
module mips_multicycle_control
  import mips_ctrl_pkg::*;
#(
  parameter bit ILLEGAL_TRAP = 1'b1,
  parameter int CNT_W        = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [5:0]       opcode,
  input  logic             mem_ready,
  output logic             PCWrite,
  output logic             PCWriteCond,
  output logic             IorD,
  output logic             MemRead,
  output logic             MemWrite,
  output logic             IRWrite,
  output logic             MemtoReg,
  output logic             RegDst,
  output logic             RegWrite,
  output logic             ALUSrcA,
  output logic [1:0]       ALUSrcB,
  output logic [1:0]       ALUOp,
  output logic [1:0]       PCSource,
  output logic             illegal_op,
  output logic             halted,
  output logic [CNT_W-1:0] instr_count
);

  state_t           r_state;
  state_t           w_next;
  logic             w_retire;
  logic [CNT_W-1:0] r_count;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // NOTE: every signal driven here gets a default first, so no path leaves a
  // value unassigned and no latch is inferred.
  always_comb begin
    w_next      = r_state;
    w_retire    = 1'b0;
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    IorD        = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    IRWrite     = 1'b0;
    MemtoReg    = 1'b0;
    RegDst      = 1'b0;
    RegWrite    = 1'b0;
    ALUSrcA     = 1'b0;
    ALUSrcB     = SRCB_RT;
    ALUOp       = ALUOP_ADD;
    PCSource    = PCSRC_ALU;
    illegal_op  = 1'b0;
    halted      = 1'b0;

    case (r_state)
      S_IDLE: w_next = S_FETCH;

      S_FETCH: begin
        // PC+4 is computed every FETCH cycle but only committed with the IR load.
        MemRead = 1'b1;
        ALUSrcB = SRCB_FOUR;
        IRWrite = mem_ready;
        PCWrite = mem_ready;
        if (mem_ready) w_next = S_DECODE;
      end

      S_DECODE: begin
        // Branch target is precomputed into ALUOut while the opcode decodes.
        ALUSrcB = SRCB_IMM_SH2;
        case (opcode)
          OP_RTYPE:     w_next = S_EXEC;
          OP_LW, OP_SW: w_next = S_MEMADR;
          OP_BEQ:       w_next = S_BRANCH;
          OP_ADDI:      w_next = S_ADDIEX;
          OP_J:         w_next = S_JUMP;
          default: begin
            illegal_op = 1'b1;
            w_next     = ILLEGAL_TRAP ? S_HALT : S_FETCH;
          end
        endcase
      end

      S_MEMADR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = SRCB_IMM;
        w_next  = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
      end

      S_MEMRD: begin
        MemRead = 1'b1;
        IorD    = 1'b1;
        if (mem_ready) w_next = S_MEMWB;
      end

      S_MEMWB: begin
        RegWrite = 1'b1;
        MemtoReg = 1'b1;
        w_next   = S_FETCH;
        w_retire = 1'b1;
      end

      S_MEMWR: begin
        MemWrite = 1'b1;
        IorD     = 1'b1;
        if (mem_ready) begin
          w_next   = S_FETCH;
          w_retire = 1'b1;
        end
      end

      S_EXEC: begin
        ALUSrcA = 1'b1;
        ALUOp   = ALUOP_FUNCT;
        w_next  = S_ALUWB;
      end

      S_ALUWB: begin
        RegWrite = 1'b1;
        RegDst   = 1'b1;
        w_next   = S_FETCH;
        w_retire = 1'b1;
      end

      S_BRANCH: begin
        ALUSrcA     = 1'b1;
        ALUOp       = ALUOP_SUB;
        PCWriteCond = 1'b1;
        PCSource    = PCSRC_ALUOUT;
        w_next      = S_FETCH;
        w_retire    = 1'b1;
      end

      S_ADDIEX: begin
        ALUSrcA = 1'b1;
        ALUSrcB = SRCB_IMM;
        w_next  = S_ADDIWB;
      end

      S_ADDIWB: begin
        RegWrite = 1'b1;
        w_next   = S_FETCH;
        w_retire = 1'b1;
      end

      S_JUMP: begin
        PCWrite  = 1'b1;
        PCSource = PCSRC_JUMP;
        w_next   = S_FETCH;
        w_retire = 1'b1;
      end

      S_HALT: halted = 1'b1;

      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        r_count <= '0;
    else if (w_retire) r_count <= r_count + CNT_W'(1);
  end

  assign instr_count = r_count;

endmodule

// File: tb/tb_mips_multicycle_control.sv
// Scoreboard bench for mips_multicycle_control: expected per-cycle control
// vectors are queued per instruction and compared as the FSM walks its states.
module tb_mips_multicycle_control;

  localparam int T_IDLE = 0, T_FETCH = 1, T_DECODE = 2, T_DECILL = 3, T_MEMADR = 4,
                 T_MEMRD = 5, T_MEMWB = 6, T_MEMWR = 7, T_EXEC = 8, T_ALUWB = 9,
                 T_BRANCH = 10, T_ADDIEX = 11, T_ADDIWB = 12, T_JUMP = 13, T_HALT = 14;

  localparam logic [5:0] C_RTYPE = 6'b000000, C_LW = 6'b100011, C_SW = 6'b101011,
                         C_BEQ = 6'b000100, C_ADDI = 6'b001000, C_J = 6'b000010,
                         C_BAD = 6'b111111;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [5:0] opcode = '0;
  logic mem_ready = 1'b0;

  logic a_pcw, a_pcwc, a_iord, a_mrd, a_mwr, a_irw, a_m2r, a_rdst, a_rw, a_asa, a_ill, a_hlt;
  logic [1:0] a_asb, a_aop, a_pcs;
  logic [31:0] a_cnt;
  logic b_pcw, b_pcwc, b_iord, b_mrd, b_mwr, b_irw, b_m2r, b_rdst, b_rw, b_asa, b_ill, b_hlt;
  logic [1:0] b_asb, b_aop, b_pcs;
  logic [31:0] b_cnt;
  logic [17:0] a_vec, b_vec;

  assign a_vec = {a_pcw, a_pcwc, a_iord, a_mrd, a_mwr, a_irw, a_m2r, a_rdst, a_rw, a_asa,
                  a_asb, a_aop, a_pcs, a_ill, a_hlt};
  assign b_vec = {b_pcw, b_pcwc, b_iord, b_mrd, b_mwr, b_irw, b_m2r, b_rdst, b_rw, b_asa,
                  b_asb, b_aop, b_pcs, b_ill, b_hlt};

  mips_multicycle_control #(.ILLEGAL_TRAP(1'b1), .CNT_W(32)) dut_trap (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .mem_ready(mem_ready),
    .PCWrite(a_pcw), .PCWriteCond(a_pcwc), .IorD(a_iord), .MemRead(a_mrd),
    .MemWrite(a_mwr), .IRWrite(a_irw), .MemtoReg(a_m2r), .RegDst(a_rdst),
    .RegWrite(a_rw), .ALUSrcA(a_asa), .ALUSrcB(a_asb), .ALUOp(a_aop),
    .PCSource(a_pcs), .illegal_op(a_ill), .halted(a_hlt), .instr_count(a_cnt)
  );

  mips_multicycle_control #(.ILLEGAL_TRAP(1'b0), .CNT_W(32)) dut_refetch (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .mem_ready(mem_ready),
    .PCWrite(b_pcw), .PCWriteCond(b_pcwc), .IorD(b_iord), .MemRead(b_mrd),
    .MemWrite(b_mwr), .IRWrite(b_irw), .MemtoReg(b_m2r), .RegDst(b_rdst),
    .RegWrite(b_rw), .ALUSrcA(b_asa), .ALUSrcB(b_asb), .ALUOp(b_aop),
    .PCSource(b_pcs), .illegal_op(b_ill), .halted(b_hlt), .instr_count(b_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          st;
    logic        mr;
    logic [17:0] vec;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          failures = 0;
  logic [31:0] exp_count = '0;

  // Expected control vector for one state, straight from the state output table.
  function automatic logic [17:0] vec(int s, logic mr);
    logic pcw, pcwc, iord, mrd, mwr, irw, m2r, rdst, rw, asa, ill, hlt;
    logic [1:0] asb, aop, pcs;
    {pcw, pcwc, iord, mrd, mwr, irw, m2r, rdst, rw, asa, ill, hlt} = '0;
    asb = 2'b00; aop = 2'b00; pcs = 2'b00;
    case (s)
      T_FETCH:  begin mrd = 1; asb = 2'b01; irw = mr; pcw = mr; end
      T_DECODE: asb = 2'b11;
      T_DECILL: begin asb = 2'b11; ill = 1; end
      T_MEMADR: begin asa = 1; asb = 2'b10; end
      T_MEMRD:  begin mrd = 1; iord = 1; end
      T_MEMWB:  begin rw = 1; m2r = 1; end
      T_MEMWR:  begin mwr = 1; iord = 1; end
      T_EXEC:   begin asa = 1; aop = 2'b10; end
      T_ALUWB:  begin rw = 1; rdst = 1; end
      T_BRANCH: begin asa = 1; aop = 2'b01; pcwc = 1; pcs = 2'b01; end
      T_ADDIEX: begin asa = 1; asb = 2'b10; end
      T_ADDIWB: rw = 1;
      T_JUMP:   begin pcw = 1; pcs = 2'b10; end
      T_HALT:   hlt = 1;
      default:  ;
    endcase
    return {pcw, pcwc, iord, mrd, mwr, irw, m2r, rdst, rw, asa, asb, aop, pcs, ill, hlt};
  endfunction

  function automatic logic rnd_bit();
    return logic'($urandom_range(0, 1));
  endfunction

  task automatic push(int st, logic mr);
    sb.push_back('{st, mr, vec(st, mr)});
  endtask

  // Entered and left at a falling edge; one queue entry per clock cycle.
  task automatic drain();
    exp_t e;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      mem_ready = e.mr;
      #1;
      checks++;
      if (a_vec !== e.vec) begin
        failures++;
        $display("FAIL ctrl_state%0d actual=%b required=%b", e.st, a_vec, e.vec);
      end
      @(negedge clk);
    end
  endtask

  task automatic check_counts(string tag);
    checks++;
    if (a_cnt !== exp_count) begin
      failures++;
      $display("FAIL %s_count_trap actual=%0d required=%0d", tag, a_cnt, exp_count);
    end
    checks++;
    if (b_cnt !== exp_count) begin
      failures++;
      $display("FAIL %s_count_refetch actual=%0d required=%0d", tag, b_cnt, exp_count);
    end
  endtask

  task automatic run_instr(logic [5:0] op, int fetch_waits, int mem_waits);
    opcode = op;
    repeat (fetch_waits) push(T_FETCH, 1'b0);
    push(T_FETCH, 1'b1);
    push(T_DECODE, rnd_bit());
    case (op)
      C_RTYPE: begin push(T_EXEC, rnd_bit()); push(T_ALUWB, rnd_bit()); end
      C_LW: begin
        push(T_MEMADR, rnd_bit());
        repeat (mem_waits) push(T_MEMRD, 1'b0);
        push(T_MEMRD, 1'b1);
        push(T_MEMWB, rnd_bit());
      end
      C_SW: begin
        push(T_MEMADR, rnd_bit());
        repeat (mem_waits) push(T_MEMWR, 1'b0);
        push(T_MEMWR, 1'b1);
      end
      C_BEQ:  push(T_BRANCH, rnd_bit());
      C_ADDI: begin push(T_ADDIEX, rnd_bit()); push(T_ADDIWB, rnd_bit()); end
      C_J:    push(T_JUMP, rnd_bit());
      default: ;
    endcase
    drain();
    exp_count = exp_count + 32'd1;
    check_counts("retire");
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    mem_ready = 1'b1;
    opcode = C_RTYPE;
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if (a_vec !== 18'd0 || b_vec !== 18'd0) begin
      failures++;
      $display("FAIL reset_outputs actual=%b/%b required=0", a_vec, b_vec);
    end
    exp_count = '0;
    check_counts("reset");
    @(negedge clk);
    rst_n = 1'b1;
    push(T_IDLE, 1'b1);
    drain();
  endtask

  task automatic test_rtype();
    run_instr(C_RTYPE, 0, 0);
  endtask

  task automatic test_lw_wait();
    run_instr(C_LW, 0, 2);
  endtask

  task automatic test_branch_jump();
    run_instr(C_BEQ, 0, 0);
    run_instr(C_J, 0, 0);
  endtask

  task automatic test_fetch_wait();
    run_instr(C_RTYPE, 3, 0);
  endtask

  task automatic test_back_to_back();
    run_instr(C_ADDI, 0, 0);
    run_instr(C_SW, 1, 1);
    run_instr(C_LW, 0, 0);
    run_instr(C_SW, 0, 0);
  endtask

  task automatic test_illegal();
    opcode = C_BAD;
    push(T_FETCH, 1'b1);
    push(T_DECILL, rnd_bit());
    drain();
    for (int i = 0; i < 5; i++) begin
      mem_ready = (i == 0) ? 1'b1 : rnd_bit();
      #1;
      checks++;
      if (a_vec !== vec(T_HALT, mem_ready)) begin
        failures++;
        $display("FAIL halt_hold%0d actual=%b required=%b", i, a_vec, vec(T_HALT, mem_ready));
      end
      if (i == 0) begin
        checks++;
        if (b_vec !== vec(T_FETCH, mem_ready)) begin
          failures++;
          $display("FAIL refetch actual=%b required=%b", b_vec, vec(T_FETCH, mem_ready));
        end
      end
      @(negedge clk);
    end
    check_counts("illegal");
  endtask

  task automatic test_reset_mid_memwr();
    test_reset();
    run_instr(C_ADDI, 0, 0);
    opcode = C_SW;
    push(T_FETCH, 1'b1);
    push(T_DECODE, rnd_bit());
    push(T_MEMADR, rnd_bit());
    push(T_MEMWR, 1'b0);
    drain();
    mem_ready = 1'b0;
    #1;
    checks++;
    if (a_vec !== vec(T_MEMWR, 1'b0)) begin
      failures++;
      $display("FAIL memwr_wait actual=%b required=%b", a_vec, vec(T_MEMWR, 1'b0));
    end
    #1;
    rst_n = 1'b0;
    #1;
    exp_count = '0;
    checks++;
    if (a_vec !== 18'd0) begin
      failures++;
      $display("FAIL async_reset_outputs actual=%b required=0", a_vec);
    end
    check_counts("async_reset");
    @(negedge clk);
    rst_n = 1'b1;
    push(T_IDLE, 1'b1);
    drain();
    run_instr(C_RTYPE, 0, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_rtype();
    test_lw_wait();
    test_branch_jump();
    test_fetch_wait();
    test_back_to_back();
    test_illegal();
    test_reset_mid_memwr();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
